// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding, default width and counter sizing for serial arithmetic
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bits needed to hold any value 0..w
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell
module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic BIN,
    output logic DIFF,
    output logic BOUT
);

    assign DIFF = X ^ Y ^ BIN;
    assign BOUT = (~X & Y) | (~(X ^ Y) & BIN);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per cycle
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    localparam int CW = cnt_width(WIDTH);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          load;
    logic          shift;
    logic          last;

    // Control: FSM and bit counter
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = (state == RUN);
        last       = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (START) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = FIN;
            end
            FIN: begin
                if (START) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter holds at WIDTH-1 after the last bit; only a new load clears it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                cnt <= '0;
            end else if (shift && !last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Datapath: operand shift registers, difference accumulator, borrow flop
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_acc;
    logic             borrow;
    logic             diff_bit;
    logic             borrow_bit;

    full_subtractor u_cell (
        .X    (a_sr[0]),
        .Y    (b_sr[0]),
        .BIN  (borrow),
        .DIFF (diff_bit),
        .BOUT (borrow_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_acc  <= '0;
            borrow <= 1'b0;
        end else if (load) begin
            a_sr   <= A;
            b_sr   <= B;
            d_acc  <= '0;
            borrow <= BIN;
        end else if (shift) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            d_acc  <= {diff_bit, d_acc[WIDTH-1:1]};
            borrow <= borrow_bit;
        end
    end

    // After the final bit the borrow flop holds the overall borrow-out
    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);
    assign D    = d_acc;
    assign BOUT = borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] D;
    logic         BOUT;

    logic [W:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // {borrow, difference} from a full-precision unsigned subtraction
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    endfunction

    // Issue one operation from a negedge; returns at the negedge of its DONE cycle
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit toggle);
        logic [W:0] e;
        int busy_n;
        bit got;
        START = 1'b1;
        A = a;
        B = b;
        BIN = bin;
        exp_q.push_back(model(a, b, bin));
        busy_n = 0;
        got = 1'b0;
        for (int i = 0; i < W + 6 && !got; i++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) begin
                e = exp_q.pop_front();
                check("d", 32'(D), 32'(e[W-1:0]));
                check("bout", 32'(BOUT), 32'(e[W]));
                check("busy_cycles", 32'(busy_n), 32'(W));
                check("busy_done_excl", 32'(BUSY), 32'd0);
                got = 1'b1;
                START = 1'b0;
            end else if (BUSY && toggle) begin
                A = W'($urandom);
                B = W'($urandom);
                BIN = 1'($urandom);
                START = 1'($urandom);
            end else begin
                START = 1'b0;
            end
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [W:0] e;
        int cyc;
        int last_done;
        int ops;
        int done_seen;

        RST = 1'b1;
        START = 1'b0;
        A = '0;
        B = '0;
        BIN = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        check("rst_bout", 32'(BOUT), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Basic operation, then result held in IDLE
        run_op(8'h5A, 8'h21, 1'b0, 1'b0);
        @(negedge CLK);
        check("done_single_pulse", 32'(DONE), 32'd0);
        check("d_held", 32'(D), 32'h39);
        @(negedge CLK);
        check("d_held2", 32'(D), 32'h39);

        // Boundary values
        run_op(8'h00, 8'h01, 1'b0, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1, 1'b0);
        @(negedge CLK);

        // START held high: new operands at each FIN, DONE every 9 cycles
        START = 1'b1;
        A = 8'hC3;
        B = 8'h3C;
        BIN = 1'b1;
        exp_q.push_back(model(A, B, BIN));
        last_done = -1;
        ops = 0;
        for (cyc = 1; cyc < 100 && ops < 4; cyc++) begin
            @(negedge CLK);
            if (DONE) begin
                e = exp_q.pop_front();
                check("b2b_d", 32'(D), 32'(e[W-1:0]));
                check("b2b_bout", 32'(BOUT), 32'(e[W]));
                if (last_done >= 0) check("b2b_period", 32'(cyc - last_done), 32'd9);
                last_done = cyc;
                ops++;
                if (ops < 4) begin
                    A = W'($urandom);
                    B = W'($urandom);
                    BIN = 1'($urandom);
                    exp_q.push_back(model(A, B, BIN));
                end else begin
                    START = 1'b0;
                end
            end
        end
        check("b2b_ops", 32'(ops), 32'd4);
        START = 1'b0;
        exp_q.delete();
        @(negedge CLK);

        // Reset during the 4th RUN cycle aborts without DONE
        START = 1'b1;
        A = 8'h5A;
        B = 8'h21;
        BIN = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_busy_before", 32'(BUSY), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_d", 32'(D), 32'd0);
        check("abort_bout", 32'(BOUT), 32'd0);
        done_seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        @(negedge CLK);

        // RST wins over START
        RST = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        check("rst_start_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        check("rst_start_busy2", 32'(BUSY), 32'd0);
        check("rst_start_done", 32'(DONE), 32'd0);

        // Randomized operations with inputs and START toggled during RUN
        for (int n = 0; n < 1000; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
